mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: op in 7 (inst6_0), funct3 in 3 (inst14_12), brCond in 1 (branch compare true).
REQ-004 SHALL have ports: imemReq out 1, imemAck in 1, dmemReq out 1, dmemWe out 1, dmemAck in 1.
REQ-005 SHALL have ports: instWrite, pcWrite, regWrite out 1 each; illegal out 1 (sticky trap flag); state out 4 (debug).
REQ-006 SHALL have select ports, 2 bits each, out: aluSrcA (0 PC, 1 PCRegFd, 2 rs1); aluSrcB (0 rs2, 1 imm, 2 const 4); aluOp (0 add, 1 branch compare, 2 funct-decoded); resultSrc (0 ALU reg, 1 mem data, 3 PC); pcSrc (0 ALU out, 1 ALU reg).

Function
REQ-007 SHALL be a multicycle FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXECR, EXECI, ALUWB, BRANCH, JALR, LINK, TRAP.
REQ-008 SHALL drive every output not listed for a state to 0; outputs SHALL be Moore except instWrite, pcWrite and transitions qualified by acks/brCond.
REQ-009 FETCH SHALL hold imemReq=1, A=0, B=2, aluOp=0, pcSrc=0 until imemAck=1; in the imemAck cycle instWrite=1, pcWrite=1, next DECODE.
REQ-010 DECODE SHALL drive A=1, B=1, aluOp=0 (branch/JAL target into ALU reg), then dispatch on op: R->EXECR, I-calc->EXECI, LOAD/STORE->MEMADR, B->BRANCH, JAL->LINK, JALR->JALR, any other->TRAP.
REQ-011 MEMADR SHALL drive A=2, B=1, aluOp=0; next MEMRD for LOAD, MEMWR for STORE.
REQ-012 MEMRD SHALL hold dmemReq=1, dmemWe=0 until dmemAck, then MEMWB; MEMWB SHALL drive regWrite=1, resultSrc=1, next FETCH.
REQ-013 MEMWR SHALL hold dmemReq=1, dmemWe=1 until dmemAck, then FETCH.
REQ-014 EXECR SHALL drive A=2, B=0, aluOp=2; EXECI A=2, B=1, aluOp=2; both next ALUWB; ALUWB regWrite=1, resultSrc=0, next FETCH.
REQ-015 BRANCH SHALL drive A=2, B=0, aluOp=1, pcSrc=1, pcWrite=brCond; next FETCH regardless of brCond.
REQ-016 JALR SHALL drive A=2, B=1, aluOp=0, next LINK; LINK SHALL drive regWrite=1, resultSrc=3, pcSrc=1, pcWrite=1, next FETCH.
REQ-017 Latencies with zero-wait memory (FETCH entry to next FETCH entry): R/I 4, LOAD 5, STORE 4, B 3, JAL 3, JALR 4 cycles; each memory wait cycle adds 1.
REQ-018 imemAck outside FETCH and dmemAck outside MEMRD/MEMWR SHALL be ignored.
REQ-019 TRAP SHALL be absorbing, assert illegal=1, all other outputs 0, until reset.
REQ-020 funct3 SHALL only qualify aluOp decoding downstream; controller SHALL NOT trap on funct3.
REQ-021 state output SHALL encode FETCH=0, DECODE=1, then REQ-007 order through TRAP=12.

Reset
REQ-022 RST_N low SHALL immediately force state FETCH, illegal=0; combinational outputs follow (imemReq=1 only after RST_N high).
REQ-023 Reset mid-MEMRD/MEMWR SHALL drop dmemReq asynchronously; the pending transaction is abandoned and no regWrite occurs.
REQ-024 While RST_N low all outputs SHALL be 0.

Structure
REQ-025 Opcode constants (OP_R_TYPE, OP_I_TYPE_CALC, OP_I_TYPE_JALR, OP_LOAD, OP_STORE, OP_B_TYPE, OP_J_TYPE), state encodings and select encodings SHALL live in the shared defines file.
REQ-026 SHALL be a single module, no sub-modules; next-state and output logic in separate always blocks.

Verification
REQ-027 R-type (op 0110011), imemAck high: states 0,1,EXECR,ALUWB; instWrite 1 cycle, regWrite 1 cycle in cycle 4.
REQ-028 LOAD (op 0000011), dmemAck delayed 3 cycles: dmemReq held 4 cycles, MEMWB regWrite with resultSrc=1, total 8 cycles.
REQ-029 BRANCH (op 1100011) brCond=1 -> pcWrite=1, pcSrc=1 in cycle 3; repeat brCond=0 -> pcWrite=0, both return to FETCH.
REQ-030 JALR (op 1100111): JALR then LINK; LINK shows regWrite=1, resultSrc=3, pcWrite=1, pcSrc=1.
REQ-031 op 0110111 -> TRAP, illegal=1 held 20 cycles with acks toggling; RST_N low -> illegal=0, state 0.
REQ-032 RST_N low during MEMWR wait -> dmemReq falls same cycle, no regWrite, restart at FETCH.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: state, opcode and datapath-select encodings shared by the multicycle controller.
// Revision 1.0
`default_nettype none

package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_MEMWB  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JALR   = 4'd10,
    S_LINK   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [6:0] OP_R_TYPE      = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE_CALC = 7'b0010011;
  localparam logic [6:0] OP_I_TYPE_JALR = 7'b1100111;
  localparam logic [6:0] OP_LOAD        = 7'b0000011;
  localparam logic [6:0] OP_STORE       = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE      = 7'b1100011;
  localparam logic [6:0] OP_J_TYPE      = 7'b1101111;

  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_OLDPC   = 2'd1;
  localparam logic [1:0] SRCA_RS1     = 2'd2;
  localparam logic [1:0] SRCB_RS2     = 2'd0;
  localparam logic [1:0] SRCB_IMM     = 2'd1;
  localparam logic [1:0] SRCB_FOUR    = 2'd2;
  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;
  localparam logic [1:0] RES_ALUREG   = 2'd0;
  localparam logic [1:0] RES_MEMDATA  = 2'd1;
  localparam logic [1:0] RES_PC       = 2'd3;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd0;
  localparam logic [1:0] PCSRC_ALUREG = 2'd1;

  // Opcode dispatch out of DECODE; anything unrecognised lands in TRAP.
  function automatic state_t decode_dispatch(input logic [6:0] op);
    case (op)
      OP_R_TYPE:          return S_EXECR;
      OP_I_TYPE_CALC:     return S_EXECI;
      OP_LOAD, OP_STORE:  return S_MEMADR;
      OP_B_TYPE:          return S_BRANCH;
      OP_J_TYPE:          return S_LINK;
      OP_I_TYPE_JALR:     return S_JALR;
      default:            return S_TRAP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction/data memory request-acknowledge handshake.
// Revision 1.0
`default_nettype none

interface mc_controller_if;
  logic imemReq;
  logic imemAck;
  logic dmemReq;
  logic dmemWe;
  logic dmemAck;

  modport master (output imemReq, dmemReq, dmemWe, input imemAck, dmemAck);
  modport slave  (input imemReq, dmemReq, dmemWe, output imemAck, dmemAck);
endinterface

`default_nettype wire

// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control FSM with Moore select outputs and a sticky illegal-opcode trap.
// Revision 1.0
`default_nettype none

module mc_controller
  import mc_controller_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [6:0]             op,
  input  logic [2:0]             funct3,
  input  logic                   brCond,
  mc_controller_if.master        mem,
  output logic                   instWrite,
  output logic                   pcWrite,
  output logic                   regWrite,
  output logic                   illegal,
  output logic [3:0]             state,
  output logic [1:0]             aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [1:0]             aluOp,
  output logic [1:0]             resultSrc,
  output logic [1:0]             pcSrc
);

  state_t r_state;
  state_t w_next;

  // funct3 only steers the downstream ALU decoder, never the sequencing.
  logic w_unused_funct3;
  assign w_unused_funct3 = ^funct3;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem.imemAck) w_next = S_DECODE;
      S_DECODE: w_next = decode_dispatch(op);
      S_MEMADR: w_next = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem.dmemAck) w_next = S_MEMWB;
      S_MEMWR:  if (mem.dmemAck) w_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LINK: w_next = S_FETCH;
      S_EXECR, S_EXECI: w_next = S_ALUWB;
      S_JALR:   w_next = S_LINK;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Gating on RST_N lets an in-flight memory request drop the instant reset asserts.
  always_comb begin
    mem.imemReq = 1'b0;
    mem.dmemReq = 1'b0;
    mem.dmemWe  = 1'b0;
    instWrite   = 1'b0;
    pcWrite     = 1'b0;
    regWrite    = 1'b0;
    illegal     = 1'b0;
    state       = 4'd0;
    aluSrcA     = SRCA_PC;
    aluSrcB     = SRCB_RS2;
    aluOp       = ALUOP_ADD;
    resultSrc   = RES_ALUREG;
    pcSrc       = PCSRC_ALUOUT;
    if (RST_N) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          mem.imemReq = 1'b1;
          aluSrcB     = SRCB_FOUR;
          instWrite   = mem.imemAck;
          pcWrite     = mem.imemAck;
        end
        S_DECODE: begin
          aluSrcA = SRCA_OLDPC;
          aluSrcB = SRCB_IMM;
        end
        S_MEMADR, S_JALR: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_IMM;
        end
        S_MEMRD: mem.dmemReq = 1'b1;
        S_MEMWR: begin
          mem.dmemReq = 1'b1;
          mem.dmemWe  = 1'b1;
        end
        S_MEMWB: begin
          regWrite  = 1'b1;
          resultSrc = RES_MEMDATA;
        end
        S_EXECR: begin
          aluSrcA = SRCA_RS1;
          aluOp   = ALUOP_FUNCT;
        end
        S_EXECI: begin
          aluSrcA = SRCA_RS1;
          aluSrcB = SRCB_IMM;
          aluOp   = ALUOP_FUNCT;
        end
        S_ALUWB: regWrite = 1'b1;
        S_BRANCH: begin
          aluSrcA = SRCA_RS1;
          aluOp   = ALUOP_BRANCH;
          pcSrc   = PCSRC_ALUREG;
          pcWrite = brCond;
        end
        S_LINK: begin
          regWrite  = 1'b1;
          resultSrc = RES_PC;
          pcSrc     = PCSRC_ALUREG;
          pcWrite   = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed cycle-by-cycle checks of every instruction class, memory waits, trap and reset.
// Revision 1.0
`default_nettype none

module tb_mc_controller;

  logic       CLK;
  logic       RST_N;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       brCond;
  logic       instWrite, pcWrite, regWrite, illegal;
  logic [3:0] state;
  logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc, pcSrc;

  int checks = 0;
  int errors = 0;

  mc_controller_if bus ();

  mc_controller dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .op        (op),
    .funct3    (funct3),
    .brCond    (brCond),
    .mem       (bus.master),
    .instWrite (instWrite),
    .pcWrite   (pcWrite),
    .regWrite  (regWrite),
    .illegal   (illegal),
    .state     (state),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .resultSrc (resultSrc),
    .pcSrc     (pcSrc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {state, A, B, aluOp, resultSrc, pcSrc, imemReq, dmemReq, dmemWe, instWrite, pcWrite, regWrite, illegal}
  logic [20:0] obs;
  assign obs = {state, aluSrcA, aluSrcB, aluOp, resultSrc, pcSrc,
                bus.imemReq, bus.dmemReq, bus.dmemWe, instWrite, pcWrite, regWrite, illegal};

  function automatic logic [20:0] E(input int st, input int a, input int b, input int ao,
                                    input int rs, input int ps, input bit imr, input bit dmr,
                                    input bit dwe, input bit iw, input bit pw, input bit rw,
                                    input bit ill);
    logic [3:0] s4;
    logic [1:0] a2, b2, o2, r2, p2;
    s4 = st[3:0]; a2 = a[1:0]; b2 = b[1:0]; o2 = ao[1:0]; r2 = rs[1:0]; p2 = ps[1:0];
    return {s4, a2, b2, o2, r2, p2, imr, dmr, dwe, iw, pw, rw, ill};
  endfunction

  function automatic logic [20:0] ZERO();
    return E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [20:0] FE(input bit ack);
    return E(0, 0, 2, 0, 0, 0, 1, 0, 0, ack, ack, 0, 0);
  endfunction

  function automatic logic [20:0] DEC();
    return E(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string tag, input logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; op = 7'd0; funct3 = 3'd0; brCond = 1'b0;
    bus.imemAck = 1'b0; bus.dmemAck = 1'b0;
    #3; chk("rst_idle", ZERO());
    cyc(); bus.imemAck = 1'b1; #1; chk("rst_ack_ignored", ZERO());
    cyc(); RST_N = 1'b1; bus.imemAck = 1'b0; #1; chk("fetch_wait", FE(0));
    cyc(); #1; chk("fetch_wait2", FE(0));

    // R-type, 4 cycles
    op = 7'b0110011; funct3 = 3'b111; bus.imemAck = 1'b1; #1; chk("r_fetch", FE(1));
    cyc(); #1; chk("r_decode", DEC());
    cyc(); #1; chk("r_execr", E(6, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); #1; chk("r_aluwb", E(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // LOAD with three dmem wait cycles, 8 cycles total
    cyc(); op = 7'b0000011; #1; chk("ld_fetch", FE(1));
    cyc(); bus.imemAck = 1'b0; #1; chk("ld_decode", DEC());
    cyc(); #1; chk("ld_memadr", E(2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) bus.dmemAck = 1'b1;
      #1; chk("ld_memrd", E(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    end
    cyc(); bus.dmemAck = 1'b0; #1; chk("ld_memwb", E(5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));

    // Branch taken, stray dmemAck in FETCH
    cyc(); op = 7'b1100011; brCond = 1'b1; bus.imemAck = 1'b1; bus.dmemAck = 1'b1;
    #1; chk("b_fetch", FE(1));
    cyc(); bus.dmemAck = 1'b0; #1; chk("b_decode", DEC());
    cyc(); #1; chk("b_taken", E(9, 2, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    brCond = 1'b0; #1; chk("b_cond_drop", E(9, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc(); #1; chk("b2_fetch", FE(1));
    cyc(); #1; chk("b2_decode", DEC());
    cyc(); #1; chk("b2_not_taken", E(9, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // JALR then LINK
    cyc(); op = 7'b1100111; #1; chk("jalr_fetch", FE(1));
    cyc(); #1; chk("jalr_decode", DEC());
    cyc(); #1; chk("jalr_exec", E(10, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); #1; chk("jalr_link", E(11, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 1, 0));

    // JAL straight to LINK
    cyc(); op = 7'b1101111; #1; chk("jal_fetch", FE(1));
    cyc(); #1; chk("jal_decode", DEC());
    cyc(); #1; chk("jal_link", E(11, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 1, 0));

    // STORE, reset during the dmem wait
    cyc(); op = 7'b0100011; #1; chk("st_fetch", FE(1));
    cyc(); bus.imemAck = 1'b0; #1; chk("st_decode", DEC());
    cyc(); #1; chk("st_memadr", E(2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); #1; chk("st_memwr", E(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    cyc(); #1; chk("st_memwr_wait", E(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    #1; RST_N = 1'b0; #1; chk("st_async_rst", ZERO());
    cyc(); RST_N = 1'b1; #1; chk("st_restart", FE(0));

    // I-type calc
    op = 7'b0010011; bus.imemAck = 1'b1; #1; chk("i_fetch", FE(1));
    cyc(); #1; chk("i_decode", DEC());
    cyc(); #1; chk("i_execi", E(7, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(); #1; chk("i_aluwb", E(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Unknown opcode (LUI) traps and stays there
    cyc(); op = 7'b0110111; #1; chk("t_fetch", FE(1));
    cyc(); #1; chk("t_decode", DEC());
    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.imemAck = i[0];
      bus.dmemAck = ~i[0];
      brCond      = i[1];
      #1; chk("trap_hold", E(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    RST_N = 1'b0; #1; chk("trap_rst", ZERO());
    cyc(); RST_N = 1'b1; bus.imemAck = 1'b0; bus.dmemAck = 1'b0; #1; chk("post_trap_fetch", FE(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
